// File: rtl/uart_pkg.sv
// Definitions shared by the hex-print UART controller and the message arbiter
// that feeds it: word width, arbiter state encoding and UART register map.
package uart_pkg;

  localparam int MSG_W = 16;

  // UART register offsets, shared with the controller's register file
  localparam logic [3:0] RX   = 4'h0;
  localparam logic [3:0] TX   = 4'h4;
  localparam logic [3:0] STAT = 4'h8;
  localparam logic [3:0] CTRL = 4'hC;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from last+1 with wrap. Reusable by any arbiter that keeps its own last grant.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    int idx;
    logic [IW-1:0] cand;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      idx  = (int'(last) + k) % N;
      cand = IW'(idx);
      if (!any && req[cand]) begin
        gnt_idx = cand;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_msg_arbiter.sv
// Shares one 16-bit hex-print UART controller among N_REQ requesters, each with
// a one-word holding slot; round-robin grant held until the controller accepts.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ARB_IDLE  | no word on offer; pick next full slot if any
//   ARB_OFFER | slot[grant] presented on out_data, waiting for out_ready
module uart_msg_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter bit TAG_EN = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MSG_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  output logic [MSG_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             grant_id,
  output logic                   busy
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("uart_msg_arbiter: N_REQ must be in 2..8");
  end

  arb_state_t state;
  arb_state_t state_nxt;

  logic [N_REQ-1:0] slot_full;
  logic [MSG_W-1:0] slot_data [N_REQ];

  logic [IW-1:0]    grant;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [MSG_W-1:0] pick_word;
  logic [MSG_W-1:0] pick_out;
  logic [MSG_W-1:0] out_reg;
  logic             accept;

  assign accept    = (state == ARB_OFFER) && out_ready;
  assign req_ready = ~slot_full;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req     (slot_full),
    .last    (last_grant),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Tag replaces only the top nibble so the printed line shows the source.
  assign pick_word = slot_data[pick_idx];
  assign pick_out  = TAG_EN ? {4'(pick_idx), pick_word[MSG_W-5:0]} : pick_word;

  // A full slot has ready low, so load and clear can never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_full <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && !slot_full[i]) begin
          slot_full[i] <= 1'b1;
          slot_data[i] <= req_data[MSG_W*i +: MSG_W];
        end else if (accept && grant == IW'(i)) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (pick_any) state_nxt = ARB_OFFER;
      ARB_OFFER: if (out_ready) state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // Grant and output word are captured at pick time and held through OFFER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= IW'(N_REQ - 1);
      out_reg    <= '0;
    end else if (state == ARB_IDLE && pick_any) begin
      grant   <= pick_idx;
      out_reg <= pick_out;
    end else if (accept) begin
      last_grant <= grant;
      out_reg    <= '0;
    end
  end

  always_comb begin
    out_valid = (state == ARB_OFFER);
    out_data  = out_reg;
    grant_id  = (state == ARB_OFFER) ? 3'(grant) : 3'd0;
    busy      = (|slot_full) || (state == ARB_OFFER);
  end

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Bench for uart_msg_arbiter: directed posts, expected words queued at post
// time, monitors pop and compare on every accepted output word.
module tb_uart_msg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [63:0] req_data  = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  grant_id;
  logic        busy;

  logic [63:0] req_data_t  = '0;
  logic [3:0]  req_valid_t = '0;
  logic [3:0]  req_ready_t;
  logic [15:0] out_data_t;
  logic        out_valid_t;
  logic        out_ready_t = 1'b0;
  logic [2:0]  grant_id_t;
  logic        busy_t;

  always #5 clk = ~clk;

  uart_msg_arbiter #(.N_REQ(4), .TAG_EN(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  uart_msg_arbiter #(.N_REQ(4), .TAG_EN(1'b1)) dut_tag (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data_t),
    .req_valid (req_valid_t),
    .req_ready (req_ready_t),
    .out_data  (out_data_t),
    .out_valid (out_valid_t),
    .out_ready (out_ready_t),
    .grant_id  (grant_id_t),
    .busy      (busy_t)
  );

  typedef struct packed {
    logic [2:0]  gid;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t tag_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the untagged instance: order/content plus hold stability.
  exp_t        e;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_data = '0;
  logic [2:0]  prev_gid  = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (out_valid && prev_hold) begin
        check("hold_data", out_data, prev_data);
        check("hold_gid", grant_id, prev_gid);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %h grant %0d, required no word", out_data, grant_id);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_gid", grant_id, e.gid);
        end
        prev_hold = 1'b0;
      end else begin
        prev_hold = out_valid;
        prev_data = out_data;
        prev_gid  = grant_id;
      end
    end
  end

  exp_t et;

  always @(negedge clk) begin
    if (!rst && out_valid_t && out_ready_t) begin
      if (tag_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tag_word: got %h grant %0d, required no word", out_data_t, grant_id_t);
      end else begin
        et = tag_q.pop_front();
        check("tag_data", out_data_t, et.data);
        check("tag_gid", grant_id_t, et.gid);
      end
    end
  end

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_ready", req_ready, 4'hF);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_gid", grant_id, 3'd0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_valid", out_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_gid", grant_id, 3'd0);
    end
    check("idle_ready", req_ready, 4'hF);

    // Single post, latency two cycles
    tick();
    out_ready       = 1'b1;
    req_data[15:0]  = 16'h1234;
    req_valid[0]    = 1'b1;
    exp_q.push_back('{gid: 3'd0, data: 16'h1234});
    tick();
    req_valid = '0;
    @(negedge clk);
    check("lat_c1_valid", out_valid, 1'b0);
    check("lat_c1_ready0", req_ready[0], 1'b0);
    check("lat_c1_busy", busy, 1'b1);
    @(negedge clk);
    check("lat_c2_valid", out_valid, 1'b1);
    check("lat_c2_data", out_data, 16'h1234);
    check("lat_c2_gid", grant_id, 3'd0);
    check("lat_c2_ready0", req_ready[0], 1'b0);
    @(negedge clk);
    check("lat_c3_ready0", req_ready[0], 1'b1);
    check("lat_c3_valid", out_valid, 1'b0);

    // All four at once after reset, out_ready pulsed every 5 cycles
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_data[16*i +: 16] = 16'hA000 + 16'(i);
      exp_q.push_back('{gid: 3'(i), data: 16'hA000 + 16'(i)});
    end
    req_valid = 4'hF;
    tick();
    req_valid = '0;
    @(negedge clk);
    check("all_ready", req_ready, 4'h0);
    for (int w = 0; w < 4; w++) begin
      repeat (4) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // Last grant 2, then 1 and 3 together: 3 wins via wrap rule
    out_ready       = 1'b1;
    req_data[47:32] = 16'h5552;
    req_valid[2]    = 1'b1;
    exp_q.push_back('{gid: 3'd2, data: 16'h5552});
    tick();
    req_valid = '0;
    repeat (4) tick();
    req_data[31:16] = 16'h0111;
    req_data[63:48] = 16'h0333;
    req_valid       = 4'b1010;
    exp_q.push_back('{gid: 3'd3, data: 16'h0333});
    exp_q.push_back('{gid: 3'd1, data: 16'h0111});
    tick();
    req_valid = '0;
    repeat (8) tick();

    // Reset during OFFER discards the word and restores priority to 0
    out_ready       = 1'b0;
    req_data[31:16] = 16'hBEEF;
    req_valid[1]    = 1'b1;
    tick();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("mid_valid", out_valid, 1'b1);
    check("mid_gid", grant_id, 3'd1);
    check("mid_data", out_data, 16'hBEEF);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", req_ready, 4'hF);
    check("mid_rst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("post_rst_ready", req_ready, 4'hF);
    check("post_rst_valid", out_valid, 1'b0);
    tick();
    out_ready       = 1'b1;
    req_data[15:0]  = 16'h0C00;
    req_data[47:32] = 16'h0C02;
    req_valid       = 4'b0101;
    exp_q.push_back('{gid: 3'd0, data: 16'h0C00});
    exp_q.push_back('{gid: 3'd2, data: 16'h0C02});
    tick();
    req_valid = '0;
    repeat (8) tick();

    // Tag mode
    out_ready_t       = 1'b1;
    req_data_t[47:32] = 16'hFFFF;
    req_valid_t[2]    = 1'b1;
    tag_q.push_back('{gid: 3'd2, data: 16'h2FFF});
    tick();
    req_valid_t = '0;
    repeat (6) tick();

    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0 && tag_q.size() == 0) break;
      tick();
    end
    check("queue_drained", exp_q.size(), 0);
    check("tag_queue_drained", tag_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
